// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: byte-serial fetch, decode, exec, mem, writeback.
// Optional overflow trap into HALT is enabled by defining SEQ_OVF_TRAP_EN.
module cpu_sequencer #(
    parameter logic [7:0] RESET_PC = 8'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [5:0] opcode,
    input  logic       ovf,
    output logic [7:0] pc,
    output logic [7:0] fetch_addr,
    output logic       ir_we,
    output logic [1:0] ir_idx,
    output logic [2:0] alu_op,
    output logic       alu_src_imm,
    output logic       rf_dst_rt,
    output logic       wb_sel,
    output logic       dmem_re,
    output logic [1:0] mem_idx,
    output logic       rf_we,
    output logic       illegal,
    output logic       busy,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [1:0] fidx_q, fidx_d;
    logic [1:0] midx_q, midx_d;
    logic [1:0] mlast_q, mlast_d;
    logic       load_q, load_d;
    logic [2:0] alu_op_q, alu_op_d;
    logic       imm_q, imm_d;
    logic       dst_rt_q, dst_rt_d;
    logic       wb_sel_q, wb_sel_d;
    logic       ir_we_q, ir_we_d;
    logic       dmem_re_q, dmem_re_d;
    logic       rf_we_q, rf_we_d;

    logic       dec_rsvd;
    logic       dec_imm;
    logic       dec_load;
    logic [2:0] dec_alu_op;
    logic [1:0] dec_mlast;
    logic       dec_trap;

`ifdef SEQ_OVF_TRAP_EN
    logic       trap_q, trap_d;
`else
    logic       unused_ovf;
    assign unused_ovf = ovf;
`endif

    // Opcode decode; only consumed while in DECODE.
    always_comb begin
        dec_rsvd   = (opcode >= 6'd14);
        dec_imm    = (opcode >= 6'd6) && (opcode <= 6'd13);
        dec_load   = (opcode >= 6'd11) && (opcode <= 6'd13);
        dec_trap   = (opcode == 6'd0) || (opcode == 6'd1) ||
                     (opcode == 6'd6) || (opcode == 6'd7);
        dec_alu_op = 3'd0;
        dec_mlast  = 2'd0;
        case (opcode)
            6'd0:    dec_alu_op = 3'd0;
            6'd1:    dec_alu_op = 3'd1;
            6'd2:    dec_alu_op = 3'd2;
            6'd3:    dec_alu_op = 3'd3;
            6'd4:    dec_alu_op = 3'd4;
            6'd5:    dec_alu_op = 3'd5;
            6'd6:    dec_alu_op = 3'd0;
            6'd7:    dec_alu_op = 3'd1;
            6'd8:    dec_alu_op = 3'd2;
            6'd9:    dec_alu_op = 3'd4;
            6'd10:   dec_alu_op = 3'd5;
            6'd12:   dec_mlast  = 2'd1;
            6'd13:   dec_mlast  = 2'd3;
            default: dec_alu_op = 3'd0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        fidx_d   = fidx_q;
        midx_d   = midx_q;
        mlast_d  = mlast_q;
        load_d   = load_q;
        alu_op_d = alu_op_q;
        imm_d    = imm_q;
        dst_rt_d = dst_rt_q;
        wb_sel_d = wb_sel_q;
`ifdef SEQ_OVF_TRAP_EN
        trap_d   = trap_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (fidx_q == 2'd3) begin
                    fidx_d  = 2'd0;
                    state_d = S_DECODE;
                end else begin
                    fidx_d = fidx_q + 2'd1;
                end
            end
            S_DECODE: begin
                alu_op_d = dec_rsvd ? 3'd0 : dec_alu_op;
                imm_d    = dec_imm;
                dst_rt_d = dec_imm;
                wb_sel_d = dec_load;
                load_d   = dec_load;
                mlast_d  = dec_mlast;
`ifdef SEQ_OVF_TRAP_EN
                trap_d   = dec_trap;
`endif
                if (dec_rsvd) begin
                    pc_d    = pc_q + 8'd4;
                    state_d = run ? S_FETCH : S_IDLE;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = load_q ? S_MEM : S_WB;
`ifdef SEQ_OVF_TRAP_EN
                if (trap_q && ovf) state_d = S_HALT;
`endif
            end
            S_MEM: begin
                if (midx_q == mlast_q) begin
                    midx_d  = 2'd0;
                    state_d = S_WB;
                end else begin
                    midx_d = midx_q + 2'd1;
                end
            end
            S_WB: begin
                pc_d    = pc_q + 8'd4;
                state_d = run ? S_FETCH : S_IDLE;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
        // Strobes are registered from the next state so they track state_q exactly.
        ir_we_d   = (state_d == S_FETCH);
        dmem_re_d = (state_d == S_MEM);
        rf_we_d   = (state_d == S_WB);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            fidx_q    <= 2'd0;
            midx_q    <= 2'd0;
            mlast_q   <= 2'd0;
            load_q    <= 1'b0;
            alu_op_q  <= 3'd0;
            imm_q     <= 1'b0;
            dst_rt_q  <= 1'b0;
            wb_sel_q  <= 1'b0;
            ir_we_q   <= 1'b0;
            dmem_re_q <= 1'b0;
            rf_we_q   <= 1'b0;
`ifdef SEQ_OVF_TRAP_EN
            trap_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            fidx_q    <= fidx_d;
            midx_q    <= midx_d;
            mlast_q   <= mlast_d;
            load_q    <= load_d;
            alu_op_q  <= alu_op_d;
            imm_q     <= imm_d;
            dst_rt_q  <= dst_rt_d;
            wb_sel_q  <= wb_sel_d;
            ir_we_q   <= ir_we_d;
            dmem_re_q <= dmem_re_d;
            rf_we_q   <= rf_we_d;
`ifdef SEQ_OVF_TRAP_EN
            trap_q    <= trap_d;
`endif
        end
    end

    assign pc          = pc_q;
    assign fetch_addr  = pc_q + {6'd0, fidx_q};
    assign ir_we       = ir_we_q;
    assign ir_idx      = fidx_q;
    assign alu_op      = alu_op_q;
    assign alu_src_imm = imm_q;
    assign rf_dst_rt   = dst_rt_q;
    assign wb_sel      = wb_sel_q;
    assign dmem_re     = dmem_re_q;
    assign mem_idx     = midx_q;
    assign rf_we       = rf_we_q;
    assign illegal     = (state_q == S_DECODE) && dec_rsvd;
    assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
    assign state       = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer; cycle 1 is the first cycle spent in FETCH.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       ovf = 1'b0;
    logic [7:0] pc, fetch_addr;
    logic       ir_we, alu_src_imm, rf_dst_rt, wb_sel, dmem_re;
    logic       rf_we, illegal, busy;
    logic [1:0] ir_idx, mem_idx;
    logic [2:0] alu_op, state;

    int vectors = 0;
    int errors = 0;

    cpu_sequencer dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .ovf(ovf),
        .pc(pc), .fetch_addr(fetch_addr), .ir_we(ir_we), .ir_idx(ir_idx),
        .alu_op(alu_op), .alu_src_imm(alu_src_imm), .rf_dst_rt(rf_dst_rt),
        .wb_sel(wb_sel), .dmem_re(dmem_re), .mem_idx(mem_idx), .rf_we(rf_we),
        .illegal(illegal), .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        vectors++;
        if ({state, pc, ir_we, dmem_re, rf_we, busy, illegal} !== 16'd0) begin
            errors++;
            $display("FAIL reset: state=%0d pc=%0d strobes=%b%b%b busy=%b ill=%b, want all 0",
                     state, pc, ir_we, dmem_re, rf_we, busy, illegal);
        end
        vectors++;
        if ({alu_op, alu_src_imm, rf_dst_rt, wb_sel, ir_idx, mem_idx} !== 10'd0) begin
            errors++;
            $display("FAIL reset_ctl: alu_op=%0d imm=%b rt=%b wb=%b idx=%0d/%0d, want 0",
                     alu_op, alu_src_imm, rf_dst_rt, wb_sel, ir_idx, mem_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_alu();
        opcode = 6'b000000;
        run = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c <= 4) begin
                vectors++;
                if (ir_we !== 1'b1 || ir_idx !== 2'(c - 1) || fetch_addr !== 8'(c - 1)) begin
                    errors++;
                    $display("FAIL alu_fetch c%0d: ir_we=%b idx=%0d addr=%0d, want 1 %0d %0d",
                             c, ir_we, ir_idx, fetch_addr, c - 1, c - 1);
                end
            end
            if (c <= 7) begin
                vectors++;
                if (rf_we !== (c == 7)) begin
                    errors++;
                    $display("FAIL alu_rf_we c%0d: got %b want %b", c, rf_we, c == 7);
                end
            end
            if (c == 6) begin
                vectors++;
                if (state !== 3'd3 || rf_dst_rt !== 1'b0 || alu_op !== 3'd0 || alu_src_imm !== 1'b0) begin
                    errors++;
                    $display("FAIL alu_exec: state=%0d rt=%b op=%0d imm=%b, want 3 0 0 0",
                             state, rf_dst_rt, alu_op, alu_src_imm);
                end
            end
            if (c == 7) run = 1'b0;
            if (c == 8) begin
                vectors++;
                if (pc !== 8'd4 || state !== 3'd0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL alu_done: pc=%0d state=%0d busy=%b, want 4 0 0", pc, state, busy);
                end
            end
        end
    endtask

    task automatic test_load_word();
        opcode = 6'b001101;
        run = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c <= 11) begin
                vectors++;
                if (dmem_re !== (c >= 7 && c <= 10) || rf_we !== (c == 11)) begin
                    errors++;
                    $display("FAIL lw_strobe c%0d: dmem_re=%b rf_we=%b", c, dmem_re, rf_we);
                end
            end
            if (c >= 7 && c <= 10) begin
                vectors++;
                if (mem_idx !== 2'(c - 7) || wb_sel !== 1'b1) begin
                    errors++;
                    $display("FAIL lw_mem c%0d: mem_idx=%0d wb_sel=%b, want %0d 1",
                             c, mem_idx, wb_sel, c - 7);
                end
            end
            if (c == 11) run = 1'b0;
            if (c == 12) begin
                vectors++;
                if (pc !== 8'd8 || state !== 3'd0) begin
                    errors++;
                    $display("FAIL lw_done: pc=%0d state=%0d, want 8 0", pc, state);
                end
            end
        end
    endtask

    task automatic test_illegal();
        int n;
        opcode = 6'b010010;
        run = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            vectors++;
            if (rf_we !== 1'b0 || illegal !== (c == 5)) begin
                errors++;
                $display("FAIL ill_c%0d: rf_we=%b illegal=%b, want 0 %b", c, rf_we, illegal, c == 5);
            end
            if (c == 6) begin
                vectors++;
                if (state !== 3'd1 || pc !== 8'd12 || ir_idx !== 2'd0) begin
                    errors++;
                    $display("FAIL ill_next: state=%0d pc=%0d idx=%0d, want 1 12 0", state, pc, ir_idx);
                end
                run = 1'b0;
            end
        end
        n = 0;
        while (state !== 3'd0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (state !== 3'd0 || pc !== 8'd16) begin
            errors++;
            $display("FAIL ill_idle: state=%0d pc=%0d, want 0 16", state, pc);
        end
    endtask

    task automatic test_reset_mid_mem();
        opcode = 6'b001100;
        run = 1'b1;
        repeat (7) @(negedge clk);
        vectors++;
        if (state !== 3'd4 || dmem_re !== 1'b1) begin
            errors++;
            $display("FAIL rmm_inmem: state=%0d dmem_re=%b, want 4 1", state, dmem_re);
        end
        run = 1'b0;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (state !== 3'd0 || pc !== 8'd0 || dmem_re !== 1'b0 || wb_sel !== 1'b0 || mem_idx !== 2'd0) begin
            errors++;
            $display("FAIL rmm_reset: state=%0d pc=%0d re=%b wb=%b idx=%0d, want 0 0 0 0 0",
                     state, pc, dmem_re, wb_sel, mem_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            vectors++;
            if (rf_we !== 1'b0 || state !== 3'd0) begin
                errors++;
                $display("FAIL rmm_after c%0d: rf_we=%b state=%0d, want 0 0", c, rf_we, state);
            end
        end
    endtask

    task automatic test_back_to_back();
        int hits;
        hits = 0;
        opcode = 6'b000101;
        run = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (rf_we === 1'b1) begin
                hits++;
                vectors++;
                if (c != 7 && c != 14) begin
                    errors++;
                    $display("FAIL b2b_rf_we: pulse at cycle %0d, want 7 or 14", c);
                end
            end
            if (c == 6) begin
                vectors++;
                if (alu_op !== 3'd5 || alu_src_imm !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_slt: op=%0d imm=%b, want 5 0", alu_op, alu_src_imm);
                end
            end
            if (c == 8) begin
                vectors++;
                if (state !== 3'd1 || pc !== 8'd4) begin
                    errors++;
                    $display("FAIL b2b_refetch: state=%0d pc=%0d, want 1 4", state, pc);
                end
                opcode = 6'b001001;
            end
            if (c == 13) begin
                vectors++;
                if (alu_op !== 3'd4 || alu_src_imm !== 1'b1 || rf_dst_rt !== 1'b1 || wb_sel !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_ori: op=%0d imm=%b rt=%b wb=%b, want 4 1 1 0",
                             alu_op, alu_src_imm, rf_dst_rt, wb_sel);
                end
            end
            if (c == 14) run = 1'b0;
        end
        vectors++;
        if (hits != 2 || pc !== 8'd8 || state !== 3'd0) begin
            errors++;
            $display("FAIL b2b_done: pulses=%0d pc=%0d state=%0d, want 2 8 0", hits, pc, state);
        end
    endtask

    task automatic test_wrap();
        int n;
        int hits;
        opcode = 6'h3f;
        run = 1'b1;
        n = 0;
        while (!(pc === 8'd252 && state === 3'd1) && n < 400) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (pc !== 8'd252 || state !== 3'd1 || ir_idx !== 2'd0) begin
            errors++;
            $display("FAIL wrap_reach: pc=%0d state=%0d idx=%0d after %0d cycles, want 252 1 0",
                     pc, state, ir_idx, n);
        end
        opcode = 6'b000000;
        @(negedge clk);
        run = 1'b0;
        hits = 0;
        n = 0;
        while (state !== 3'd0 && n < 12) begin
            @(negedge clk);
            if (rf_we === 1'b1) hits++;
            n++;
        end
        vectors++;
        if (hits != 1 || pc !== 8'd0 || state !== 3'd0) begin
            errors++;
            $display("FAIL wrap_done: pulses=%0d pc=%0d state=%0d, want 1 0 0", hits, pc, state);
        end
    endtask

    task automatic test_ovf();
        int hits;
        hits = 0;
        opcode = 6'b000110;
        ovf = 1'b1;
        run = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (rf_we === 1'b1) hits++;
            if (c == 7) run = 1'b0;
        end
`ifdef SEQ_OVF_TRAP_EN
        vectors++;
        if (state !== 3'd6 || hits != 0 || pc !== 8'd0 || busy !== 1'b0 || ir_we !== 1'b0) begin
            errors++;
            $display("FAIL ovf_trap: state=%0d pulses=%0d pc=%0d busy=%b ir_we=%b, want 6 0 0 0 0",
                     state, hits, pc, busy, ir_we);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (state !== 3'd0) begin
            errors++;
            $display("FAIL ovf_reset: state=%0d want 0", state);
        end
        @(negedge clk);
        rst_n = 1'b1;
`else
        vectors++;
        if (hits != 1 || pc !== 8'd4 || state !== 3'd0) begin
            errors++;
            $display("FAIL ovf_ignored: pulses=%0d pc=%0d state=%0d, want 1 4 0", hits, pc, state);
        end
`endif
        ovf = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_word();
        test_illegal();
        test_reset_mid_mem();
        test_back_to_back();
        test_wrap();
        test_ovf();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'd0, the PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on posedge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port run, input, 1, level enable to start and continue instruction sequencing.
REQ-005 SHALL have port opcode, input, 6, instruction[31:26] from the instruction register, sampled in DECODE.
REQ-006 SHALL have port ovf, input, 1, ALU carry/overflow, sampled in EXEC.
REQ-007 SHALL have port pc, output, 8, current instruction address.
REQ-008 SHALL have port fetch_addr, output, 8, byte address to instruction memory, equal to pc + ir_idx.
REQ-009 SHALL have ports ir_we, output, 1, and ir_idx, output, 2: instruction-register byte write strobe and byte index (0 = bits 31:24).
REQ-010 SHALL have ports alu_op, output, 3, alu_src_imm, output, 1, rf_dst_rt, output, 1, and wb_sel, output, 1 (0 = ALU, 1 = memory): decoded controls.
REQ-011 SHALL have ports dmem_re, output, 1, and mem_idx, output, 2: data-memory byte read strobe and byte offset from the effective address.
REQ-012 SHALL have port rf_we, output, 1, a one-cycle register-file write pulse.
REQ-013 SHALL have ports illegal, output, 1, busy, output, 1, and state, output, 3 (debug encoding).

Function
REQ-014 SHALL implement states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, and HALT=6.
REQ-015 SHALL move IDLE->FETCH on a clock edge with run=1; busy SHALL be 0 only in IDLE and HALT.
REQ-016 SHALL stay in FETCH for 4 cycles with ir_we=1 and ir_idx counting 0,1,2,3, then move to DECODE.
REQ-017 SHALL in DECODE register controls that are held until the next DECODE: alu_op 000000->0 add, 000001->1 sub, 000010->2 and, 000011->3 nor, 000100->4 or, 000101->5 slt, 000110->0, 000111->1, 001000->2, 001001->4, 001010->5, 001011..001101->0.
REQ-018 SHALL set alu_src_imm=1 and rf_dst_rt=1 for opcodes 000110..001101, and 0 otherwise; wb_sel SHALL be 1 only for 001011..001101.
REQ-019 SHALL treat opcodes 001110..111111 as reserved: one-cycle illegal pulse in DECODE, no EXEC/MEM/WB, pc+=4, then FETCH if run=1, else IDLE.
REQ-020 SHALL go EXEC->WB for ALU opcodes and EXEC->MEM for loads.
REQ-021 SHALL stay in MEM for 1 cycle (001011), 2 cycles (001100), or 4 cycles (001101) with dmem_re=1 and mem_idx counting from 0, then move to WB.
REQ-022 SHALL assert rf_we for exactly the single WB cycle, then pc+=4 and go to FETCH if run=1, else IDLE.
REQ-023 SHALL produce latency from FETCH entry to rf_we of 7 cycles for ALU opcodes and 8/9/11 cycles for byte/half/word loads.
REQ-024 SHALL wrap pc modulo 256 (252+4 -> 0).
REQ-025 SHALL ignore run deassertion mid-instruction; the current instruction SHALL complete through WB.
REQ-026 SHALL hold ir_we, dmem_re, and rf_we at 0 in IDLE and HALT; all strobes SHALL be Moore outputs decoded from state.

Reset
REQ-027 SHALL on rst_n=0 immediately force state=IDLE, pc=RESET_PC, all counters 0, all strobes and decoded controls 0, and illegal 0.
REQ-028 SHALL, if reset occurs mid-instruction, abandon that instruction with no rf_we pulse; after release the sequencer restarts from RESET_PC.

Configuration
REQ-029 SHALL, when SEQ_OVF_TRAP_EN is defined, on ovf=1 in EXEC for opcodes 000000, 000001, 000110, or 000111, go to HALT instead of WB: no rf_we, pc frozen at the faulting instruction, HALT left only by reset.
REQ-030 SHALL, when SEQ_OVF_TRAP_EN is undefined, ignore ovf entirely; HALT SHALL be unreachable and may be omitted.

Verification
REQ-031 SHALL verify: reset, run=1, opcode 000000 -> ir_idx 0..3 on cycles 1-4, rf_we on cycle 7, pc 0->4, rf_dst_rt=0.
REQ-032 SHALL verify: opcode 001101 -> dmem_re for 4 cycles with mem_idx 0,1,2,3, wb_sel=1, rf_we on cycle 11.
REQ-033 SHALL verify: opcode 010010 -> illegal pulse in DECODE, no rf_we, next FETCH at pc+4 after 5 cycles.
REQ-034 SHALL verify: run dropped during FETCH of the instruction at pc=252 -> instruction completes, pc=0, state=IDLE.
REQ-035 SHALL verify: rst_n pulsed low during MEM of 001100 -> IDLE immediately, no rf_we, pc=RESET_PC.
REQ-036 SHALL verify: with SEQ_OVF_TRAP_EN defined, opcode 000110 with ovf=1 -> state=6, rf_we never asserted, pc unchanged; with it undefined -> rf_we asserted normally.
